// File: rtl/bus_io_timer.sv
// ============================================================================
// bus_io_timer : 8-byte memory-mapped I/O port plus 16-bit timer with IRQ/NMI
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_io_timer #(
    parameter logic [15:0] BASE = 16'hBFF8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        sel,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic        irq,
    output logic        nmi
);

    localparam logic [2:0] OFF_PORT = 3'd0;
    localparam logic [2:0] OFF_PIN  = 3'd1;
    localparam logic [2:0] OFF_TLO  = 3'd2;
    localparam logic [2:0] OFF_THI  = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;
    localparam logic [2:0] OFF_STAT = 3'd5;

    logic        hit_w, wr_w, rd_w;
    logic [2:0]  off_w;
    logic [7:0]  rdata_w;

    logic [7:0]  data_q,    data_d;
    logic        sel_q,     sel_d;
    logic [7:0]  port_q,    port_d;
    logic [15:0] latch_q,   latch_d;
    logic [15:0] count_q,   count_d;
    logic [7:0]  hi_snap_q, hi_snap_d;
    logic        en_q,      en_d;
    logic        reload_q,  reload_d;
    logic        irq_en_q,  irq_en_d;
    logic        nmi_en_q,  nmi_en_d;
    logic        uf_q,      uf_d;
    logic        uf_set_w;

    assign hit_w = (address_next[15:3] == BASE[15:3]);
    assign off_w = address_next[2:0];
    assign wr_w  = hit_w & write_next;
    assign rd_w  = hit_w & ~write_next;

    assign irq      = uf_q & irq_en_q;
    assign nmi      = uf_q & nmi_en_q;
    assign data_o   = data_q;
    assign sel      = sel_q;
    assign port_out = port_q;

    // Read data always reflects register state before this edge's updates.
    always_comb begin
        rdata_w = 8'h00;
        case (off_w)
            OFF_PORT: rdata_w = port_q;
            OFF_PIN:  rdata_w = port_in;
            OFF_TLO:  rdata_w = count_q[7:0];
            OFF_THI:  rdata_w = hi_snap_q;
            OFF_CTRL: rdata_w = {4'b0000, nmi_en_q, irq_en_q, reload_q, en_q};
            OFF_STAT: rdata_w = {irq, 6'b000000, uf_q};
            default:  rdata_w = 8'h00;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        sel_d     = hit_w;
        port_d    = port_q;
        latch_d   = latch_q;
        count_d   = count_q;
        hi_snap_d = hi_snap_q;
        en_d      = en_q;
        reload_d  = reload_q;
        irq_en_d  = irq_en_q;
        nmi_en_d  = nmi_en_q;
        uf_d      = uf_q;
        uf_set_w  = 1'b0;

        if (hit_w) begin
            data_d = rdata_w;
        end
        if (rd_w && off_w == OFF_TLO) begin
            hi_snap_d = count_q[15:8];
        end

        // Timer step uses pre-write control; register writes below override it.
        if (en_q) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                uf_set_w = 1'b1;
                if (reload_q) begin
                    count_d = latch_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_w) begin
            case (off_w)
                OFF_PORT: port_d = data_i;
                OFF_TLO:  latch_d[7:0] = data_i;
                OFF_THI: begin
                    latch_d[15:8] = data_i;
                    count_d       = {data_i, latch_q[7:0]};
                    en_d          = 1'b1;
                end
                OFF_CTRL: begin
                    en_d     = data_i[0];
                    reload_d = data_i[1];
                    irq_en_d = data_i[2];
                    nmi_en_d = data_i[3];
                end
                OFF_STAT: begin
                    if (data_i[0]) begin
                        uf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (uf_set_w) begin
            uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= 8'h00;
            sel_q     <= 1'b0;
            port_q    <= 8'h00;
            latch_q   <= 16'hFFFF;
            count_q   <= 16'hFFFF;
            hi_snap_q <= 8'h00;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            nmi_en_q  <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            data_q    <= data_d;
            sel_q     <= sel_d;
            port_q    <= port_d;
            latch_q   <= latch_d;
            count_q   <= count_d;
            hi_snap_q <= hi_snap_d;
            en_q      <= en_d;
            reload_q  <= reload_d;
            irq_en_q  <= irq_en_d;
            nmi_en_q  <= nmi_en_d;
            uf_q      <= uf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_io_timer.sv
// ============================================================================
// tb_bus_io_timer : directed self-checking bench for bus_io_timer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_io_timer;

    localparam logic [15:0] BASE = 16'hBFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_next;
    logic        write_next;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        sel;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic        irq;
    logic        nmi;

    int checks   = 0;
    int failures = 0;

    bus_io_timer #(.BASE(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .address_next (address_next),
        .write_next   (write_next),
        .data_i       (data_i),
        .data_o       (data_o),
        .sel          (sel),
        .port_in      (port_in),
        .port_out     (port_out),
        .irq          (irq),
        .nmi          (nmi)
    );

    always #5 clk = ~clk;

    // One bus cycle: present the access, let one edge take it, then go idle.
    task automatic access(input logic [15:0] a, input logic we, input logic [7:0] d);
        address_next = a;
        write_next   = we;
        data_i       = d;
        @(posedge clk);
        #1;
        address_next = 16'h0000;
        write_next   = 1'b0;
        data_i       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        address_next = 16'h0000;
        write_next   = 1'b0;
        data_i       = 8'h00;
        port_in      = 8'h00;
        idle(3);
        reset = 1'b1;
        idle(1);
        checks++;
        if ({data_o, sel, port_out, irq, nmi} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {data_o, sel, port_out, irq, nmi});
        end
        access(BASE + 16'd3, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00 || sel !== 1'b1) begin
            failures++;
            $display("FAIL reset_thi got=%h sel=%b exp=00 sel=1", data_o, sel);
        end
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'hFF) begin
            failures++;
            $display("FAIL reset_tlo got=%h exp=ff", data_o);
        end
        idle(1);
        checks++;
        if (sel !== 1'b0 || data_o !== 8'hFF) begin
            failures++;
            $display("FAIL idle_hold got=%h sel=%b exp=ff sel=0", data_o, sel);
        end
    endtask

    task automatic test_port;
        access(BASE, 1'b1, 8'hA5);
        checks++;
        if (port_out !== 8'hA5) begin
            failures++;
            $display("FAIL port_write got=%h exp=a5", port_out);
        end
        port_in = 8'h3C;
        access(BASE + 16'd1, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h3C || sel !== 1'b1) begin
            failures++;
            $display("FAIL pin_read got=%h sel=%b exp=3c sel=1", data_o, sel);
        end
        access(16'hBFF0, 1'b1, 8'h5A);
        checks++;
        if (sel !== 1'b0 || port_out !== 8'hA5) begin
            failures++;
            $display("FAIL miss_access sel=%b port=%h exp sel=0 port=a5", sel, port_out);
        end
        access(BASE, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'hA5) begin
            failures++;
            $display("FAIL port_read got=%h exp=a5", data_o);
        end
        access(BASE + 16'd7, 1'b1, 8'h77);
        access(BASE + 16'd7, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00 || sel !== 1'b1) begin
            failures++;
            $display("FAIL unused_reg got=%h exp=00", data_o);
        end
    endtask

    task automatic test_oneshot;
        access(BASE + 16'd4, 1'b1, 8'h04);
        access(BASE + 16'd2, 1'b1, 8'h03);
        access(BASE + 16'd3, 1'b1, 8'h00);
        idle(3);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_early irq=%b exp=0", irq);
        end
        idle(1);
        checks++;
        if (irq !== 1'b1 || nmi !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_uf irq=%b nmi=%b exp irq=1 nmi=0", irq, nmi);
        end
        access(BASE + 16'd5, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h81) begin
            failures++;
            $display("FAIL oneshot_stat got=%h exp=81", data_o);
        end
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL oneshot_count got=%h exp=00", data_o);
        end
        access(BASE + 16'd4, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h04) begin
            failures++;
            $display("FAIL oneshot_ctrl got=%h exp=04", data_o);
        end
        access(BASE + 16'd5, 1'b1, 8'h01);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_w1c irq=%b exp=0", irq);
        end
    endtask

    task automatic test_autoreload;
        access(BASE + 16'd4, 1'b1, 8'h0A);
        access(BASE + 16'd2, 1'b1, 8'h01);
        access(BASE + 16'd3, 1'b1, 8'h00);
        idle(1);
        checks++;
        if (nmi !== 1'b0) begin
            failures++;
            $display("FAIL reload_pre nmi=%b exp=0", nmi);
        end
        idle(1);
        checks++;
        if (nmi !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reload_first nmi=%b irq=%b exp nmi=1 irq=0", nmi, irq);
        end
        access(BASE + 16'd5, 1'b1, 8'h01);
        checks++;
        if (nmi !== 1'b0) begin
            failures++;
            $display("FAIL reload_w1c nmi=%b exp=0", nmi);
        end
        access(BASE + 16'd5, 1'b1, 8'h01);
        checks++;
        if (nmi !== 1'b1) begin
            failures++;
            $display("FAIL w1c_vs_uf nmi=%b exp=1", nmi);
        end
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h01) begin
            failures++;
            $display("FAIL reload_count got=%h exp=01", data_o);
        end
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL reload_zero got=%h exp=00", data_o);
        end
    endtask

    task automatic test_snapshot;
        access(BASE + 16'd2, 1'b1, 8'h00);
        access(BASE + 16'd3, 1'b1, 8'h12);
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL snap_tlo got=%h exp=00", data_o);
        end
        idle(20);
        access(BASE + 16'd3, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h12) begin
            failures++;
            $display("FAIL snap_thi got=%h exp=12", data_o);
        end
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'hEA) begin
            failures++;
            $display("FAIL snap_live got=%h exp=ea", data_o);
        end
        access(BASE + 16'd3, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h11) begin
            failures++;
            $display("FAIL snap_new got=%h exp=11", data_o);
        end
    endtask

    task automatic test_async_reset;
        access(BASE + 16'd4, 1'b1, 8'h06);
        access(BASE + 16'd2, 1'b1, 8'h02);
        access(BASE + 16'd3, 1'b1, 8'h00);
        idle(3);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq irq=%b exp=1", irq);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({irq, nmi, sel, port_out, data_o} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {irq, nmi, sel, port_out, data_o});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(BASE + 16'd3, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL rst_hisnap got=%h exp=00", data_o);
        end
        access(BASE + 16'd4, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'h00) begin
            failures++;
            $display("FAIL rst_ctrl got=%h exp=00", data_o);
        end
        idle(2);
        access(BASE + 16'd2, 1'b0, 8'h00);
        checks++;
        if (data_o !== 8'hFF) begin
            failures++;
            $display("FAIL rst_count got=%h exp=ff", data_o);
        end
    endtask

    initial begin
        test_reset();
        test_port();
        test_oneshot();
        test_autoreload();
        test_snapshot();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_io_timer.md
Name: bus_io_timer

Overview:
- Memory-mapped peripheral on the cpu6502 bus: the responder end of the CPU's next-cycle address/write/data interface.
- Occupies 8 bytes at BASE..BASE+7 and provides four functions:
  - an 8-bit output port;
  - an 8-bit input port;
  - a 16-bit down-counting timer with latch and auto-reload;
  - level irq/nmi outputs that feed the CPU directly.
- Read data is registered one cycle after the address is presented, so it lines up with the CPU's registered address exactly as the synchronous memory does. The top level muxes it in using sel.

Parameters:
BASE, 16'hBFF8, base address; must be 8-byte aligned; the block decodes address_next[15:3] == BASE[15:3].

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
address_next  input  16  CPU next-cycle address
write_next  input  1  CPU next-cycle write strobe
data_i  input  8  CPU next-cycle write data (CPU data_o_next)
data_o  output  8  registered read data, valid while CPU address equals the decoded address
sel  output  1  registered hit; top level selects data_o onto CPU data_i when 1
port_in  input  8  external input pins
port_out  output  8  output port register
irq  output  1  level interrupt request, active-high
nmi  output  1  level NMI request, active-high (CPU edge-detects)

Behaviour:
- Access definitions:
  - hit = address_next[15:3] == BASE[15:3]; off = address_next[2:0].
  - Write: hit & write_next at posedge. Read: hit & !write_next at posedge.
  - The CPU's dummy reads count as reads.
- Register map (R / W):
  - 0 PORT: R = port_out; W = port_out.
  - 1 PIN: R = port_in sampled at the edge; W ignored.
  - 2 TLO: R = count[7:0], and the same edge snapshots count[15:8] into hi_snap; W = latch[7:0].
  - 3 THI: R = hi_snap; W = latch[15:8], then count <= {data_i, latch[7:0]} and ctrl.en <= 1.
  - 4 CTRL: bit0 en, bit1 reload, bit2 irq_en, bit3 nmi_en; bits 7:4 read 0.
  - 5 STAT: bit0 uf flag, bit7 = irq; W: writing 1 to bit0 clears uf.
  - 6, 7: read 8'h00; writes ignored.
- Read data timing:
  - At a posedge with hit, data_o <= the register value as it stood before that edge's updates, and sel <= 1.
  - Without hit, sel <= 0 and data_o holds its value.
- Timer:
  - While en = 1, each posedge: if count != 0, count <= count - 1.
  - If count == 0: uf <= 1. Then, if reload = 1, count <= latch; else en <= 0 and count stays 0.
  - A 16-bit count therefore underflows every latch+1 cycles under auto-reload.
  - While en = 0, count holds.
- Outputs:
  - irq = uf & irq_en; nmi = uf & nmi_en. Both are combinational from registers, so there is no glitch source.
- Simultaneous events:
  - THI write on the same edge as underflow: the write wins for count and en; uf is still set.
  - STAT W1C on the same edge as underflow: set wins, so uf stays 1.
  - CTRL write on the same edge as underflow: the written en and reload take effect. The count update for that edge uses the pre-write reload.
  - TLO read on the same edge as a decrement: snapshot and data_o use the pre-decrement count.
- Reset (reset = 0, asynchronous, any time including mid-count):
  - data_o = 0, sel = 0, port_out = 0.
  - latch = 16'hFFFF, count = 16'hFFFF, hi_snap = 0.
  - ctrl = 0, uf = 0, so irq = 0 and nmi = 0.
  - The block resumes on the first posedge after reset deasserts.

Test Plan:
- Reset release: all outputs 0. Read BASE+3 -> data_o = 8'h00 one cycle later with sel = 1. Read BASE+2 -> 8'hFF.
- Port: write 8'hA5 to BASE+0 -> port_out = 8'hA5 after the edge. Drive port_in = 8'h3C and read BASE+1 -> data_o = 8'h3C. Access 16'hBFF0 -> sel = 0 and port_out unchanged.
- One-shot:
  - Write CTRL = 8'h04, TLO = 8'h03, THI = 8'h00.
  - uf and irq assert exactly 4 edges after the THI write; then en = 0 and count = 0.
  - Write STAT = 8'h01 -> irq drops the next cycle.
- Auto-reload with NMI:
  - Write CTRL = 8'h0A, TLO = 8'h01, THI = 8'h00.
  - Underflows occur every 2 cycles and nmi rises after the first.
  - W1C on an underflow edge leaves uf = 1.
- Snapshot: with count = 16'h1200 running, read TLO -> 8'h00 and hi_snap = 8'h12. Read THI 20 cycles later -> 8'h12 regardless of the live count.
- Assert reset mid-count with irq high -> irq, count and ctrl return to their reset values immediately, before the next clk edge.
